// File: rtl/seq_gen.sv
// seq_gen: serial pattern transmitter.
//   Latches a parallel pattern on start and shifts it out MSB-first (bit len-1
//   first, bit 0 last), one bit per clk, with a qualifying ser_valid strobe.
//   Supports variable frame length, pausing (hold) and gap-free looping.
//
// Ports
//   clk        system clock, all state changes on posedge
//   rst        synchronous active-high reset
//   start      frame request, sampled only while idle
//   pattern    frame bits (WIDTH)
//   len        frame length in bits, legal 1..WIDTH
//   hold       freeze shifting while busy
//   loop       at the last-bit decision, restart the same frame with no gap
//   serOut     serial data bit (meaningful when ser_valid)
//   ser_valid  serOut carries a frame bit this cycle
//   busy       frame in progress
//   done       1-cycle pulse after a frame's last bit
//   err        1-cycle pulse when start arrives with an illegal len
module seq_gen #(
    parameter int WIDTH = 8,
    parameter int LW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LW-1:0]    len,
    input  logic             hold,
    input  logic             loop,
    output logic             serOut,
    output logic             ser_valid,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_SHIFT = 1'b1;

    localparam logic [LW-1:0] MAXLEN = LW'(WIDTH);

    logic             state;
    logic [LW-1:0]    idx;     // index of the bit currently on serOut
    logic [LW-1:0]    flen;    // latched frame length
    logic [WIDTH-1:0] pat;     // latched frame bits

    logic             len_ok;
    logic [LW-1:0]    idx_dn;
    logic [WIDTH-1:0] sh_in;   // incoming pattern aligned so its first bit is at [0]
    logic [WIDTH-1:0] sh_nxt;  // latched pattern aligned to the next bit
    logic [WIDTH-1:0] sh_top;  // latched pattern aligned to its first bit (loop restart)

    assign len_ok = (len != '0) && (len <= MAXLEN);
    assign idx_dn = idx - 1'b1;
    assign sh_in  = pattern >> (len - 1'b1);
    assign sh_nxt = pat >> idx_dn;
    assign sh_top = pat >> (flen - 1'b1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            idx       <= '0;
            flen      <= '0;
            pat       <= '0;
            serOut    <= 1'b0;
            ser_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            // done and err are single-cycle pulses
            done <= 1'b0;
            err  <= 1'b0;
            if (state == ST_IDLE) begin
                serOut    <= 1'b0;
                ser_valid <= 1'b0;
                busy      <= 1'b0;
                if (start) begin
                    if (len_ok) begin
                        // the accepting edge already drives the first bit
                        pat       <= pattern;
                        flen      <= len;
                        idx       <= len - 1'b1;
                        serOut    <= sh_in[0];
                        ser_valid <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ST_SHIFT;
                    end else begin
                        err <= 1'b1;
                    end
                end
            end else begin
                if (hold) begin
                    // freeze idx/serOut; a pending last-bit decision waits too
                    ser_valid <= 1'b0;
                end else if (idx != '0) begin
                    idx       <= idx_dn;
                    serOut    <= sh_nxt[0];
                    ser_valid <= 1'b1;
                end else if (loop) begin
                    // restart with no gap; done marks the frame boundary
                    idx       <= flen - 1'b1;
                    serOut    <= sh_top[0];
                    ser_valid <= 1'b1;
                    done      <= 1'b1;
                end else begin
                    // busy drops with done so a start in the done cycle is accepted
                    state     <= ST_IDLE;
                    serOut    <= 1'b0;
                    ser_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                end
            end
        end
    end

endmodule
